// File: rtl/seg7_pkg.sv
// Shared constants and types for seven-segment display paths.
// Segment patterns are active-low, bit order gfedcba.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned AN_W       = NUM_DIGITS;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF    = 8'hFF;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  // Registered pin state presented to the board.
  typedef struct packed {
    logic [AN_W-1:0]  an;
    logic [SEG_W-1:0] seg;
    logic             frame_done;
  } disp_t;

  localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_BLANK, frame_done: 1'b0};

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit/control inputs and display pin outputs of the scan driver.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic               enable;
  logic               load;
  logic               blank_lz;
  logic [DIGIT_W-1:0] bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7;
  logic [AN_W-1:0]    an;
  logic [SEG_W-1:0]   seg;
  logic               frame_done;

  modport master (
    output enable, load, blank_lz,
    output bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7,
    input  an, seg, frame_done
  );

  modport slave (
    input  enable, load, blank_lz,
    input  bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7,
    output an, seg, frame_done
  );
endinterface

// File: rtl/seg7_decoder.sv
// 4-bit value to active-low seven-segment pattern; A-F show hex glyphs.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    unique case (value)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit common-anode display driver with shadowed digits,
// per-slot dead time and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [PRE_W-1:0]      pre;
  logic [IDX_W-1:0]      idx;
  digits_t               shadow;
  digits_t               bcd_in;
  disp_t                 disp_q;
  disp_t                 disp_nxt_c;
  logic [SEG_W-1:0]      seg_dec_c;
  logic [NUM_DIGITS-1:0] nonzero_c;
  logic                  pre_wrap_c;
  logic                  dead_c;
  logic                  lz_blank_c;
  logic                  lit_c;

  assign bcd_in = {bus.bcd7, bus.bcd6, bus.bcd5, bus.bcd4,
                   bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};

  assign pre_wrap_c = (pre == PRE_W'(SCAN_DIV - 1));

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign dead_c = 1'b0;
    end else begin : g_dead
      assign dead_c = (pre < PRE_W'(DEAD_CYCLES));
    end
  endgenerate

  always_comb begin
    nonzero_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nonzero_c[i] = |shadow[i];
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  assign lz_blank_c = bus.blank_lz && (idx != '0) && ((nonzero_c >> idx) == '0);
  assign lit_c      = bus.enable && !dead_c && !lz_blank_c;

  seg7_decoder u_decoder (
    .value (shadow[idx]),
    .seg_c (seg_dec_c)
  );

  always_comb begin
    disp_nxt_c            = DISP_OFF;
    disp_nxt_c.frame_done = bus.enable && pre_wrap_c && (idx == IDX_W'(NUM_DIGITS - 1));
    if (lit_c) begin
      disp_nxt_c.an  = ~(AN_W'(1) << idx);
      disp_nxt_c.seg = seg_dec_c;
    end
  end

  // Shadow capture is independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (bus.load) begin
      shadow <= bcd_in;
    end
  end

  // Slot prescaler and digit index; both freeze while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (bus.enable) begin
      if (pre_wrap_c) begin
        pre <= '0;
        idx <= idx + IDX_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= DISP_OFF;
    end else begin
      disp_q <= disp_nxt_c;
    end
  end

  assign bus.an         = disp_q.an;
  assign bus.seg        = disp_q.seg;
  assign bus.frame_done = disp_q.frame_done;

endmodule
